buzzer_scheduler: RTL and testbench
===================================

// Module: buzzer_scheduler
// PURPOSE
//  Shares the single piezo speaker among three alarm sources: alarm match, countdown-timer expiry and hourly chime.
//  Latches each source's event, grants the speaker to one source by fixed priority, and sequences a beep/gap cadence.
//  Ends each session on dismiss, beep-count timeout or chime completion.
//  Sits between the clock/alarm/timer comparators and the tone generator: tone_en gates the square wave, tone_sel picks pitch.
// PARAMETERS
//  TICK_W        16     width of cadence tick counter
//  BEEP_TICKS    50     ticks tone on per beep (0.5 s at 100 Hz tick)
//  GAP_TICKS     50     ticks tone off between beeps
//  TIMEOUT_BEEPS 60     beeps before alarm/timer session auto-ends (1..255)
//  CHIME_BEEPS   2      beeps per hourly chime (1..255)
//  SNOOZE_TICKS  30000  snooze length in ticks (5 min); used only with BUZZ_SNOOZE_EN
// PORTS
//  clk         in  1  system clock
//  rst         in  1  reset, asynchronous, active-high
//  tick        in  1  1-cycle strobe, 100 Hz cadence base
//  alarm_hit   in  1  1-cycle pulse: alarm time matched
//  timer_hit   in  1  1-cycle pulse: countdown reached zero
//  chime_hit   in  1  1-cycle pulse: top of hour
//  stop_btn    in  1  debounced 1-cycle pulse: dismiss current session
//  snooze_btn  in  1  debounced 1-cycle pulse: snooze alarm (ignored without macro)
//  tone_en     out 1  speaker gate, high only in BEEP
//  tone_sel    out 2  granted source: 0 none, 1 alarm, 2 timer, 3 chime
//  busy        out 1  high in BEEP or GAP
//  dismissed   out 1  1-cycle pulse when stop_btn ends a session
// BEHAVIOUR
//  - Reset: state IDLE; pending[3:0], counters, snooze timer cleared; all outputs 0.
//  - hit pulse sets pending[src] on the same edge; re-hit of an already pending/active source has no effect (no restart).
//  - Priority alarm > timer > chime. Outputs decode registered state/cur.
//  - IDLE: any eligible pending -> BEEP, cur = highest, tick_cnt = 0, beep_cnt = 0. tone_en high 2nd edge after hit.
//  - BEEP: tick_cnt++ on tick; on tick with tick_cnt == BEEP_TICKS-1 -> GAP, tick_cnt = 0, beep_cnt++.
//  - GAP: on tick with tick_cnt == GAP_TICKS-1:
//    - done (chime: beep_cnt == CHIME_BEEPS; alarm/timer: == TIMEOUT_BEEPS) -> clear pending[cur], IDLE; no dismissed pulse.
//    - else higher-priority pending -> preempt: cur = it, beep_cnt = 0, BEEP. Preempted source stays pending; it restarts from beep 0 when re-granted.
//    - else -> BEEP.
//  - Preemption only at GAP end, never mid-beep.
//  - stop_btn in BEEP/GAP: clear pending[cur], -> IDLE, dismissed = 1 for one cycle.
//    - stop_btn beats tick in the same cycle.
//    - A same-cycle hit of cur's source is dropped.
//    - stop_btn in IDLE is ignored.
//  - Counters saturate-safe: tick_cnt TICK_W bits, beep_cnt 8 bits; parameters must fit (elaboration check).
//  - Reset mid-session: immediate IDLE, tone_en low asynchronously, all pending lost.
// CONFIGURATION
//  BUZZ_SNOOZE_EN defined:
//    - snooze_btn in BEEP/GAP with cur == alarm: clear alarm's in-flight beep_cnt, -> IDLE, load snooze_cnt = SNOOZE_TICKS.
//    - Alarm pending is ineligible while snooze_cnt != 0; snooze_cnt decrements on tick.
//    - Other sources may be served meanwhile.
//    - stop_btn with snooze_cnt != 0 and no active session clears alarm pending and snooze_cnt (dismissed pulses).
//    - snooze_btn for timer/chime is ignored.
//  BUZZ_SNOOZE_EN undefined: snooze_btn ignored, no snooze counter synthesized; otherwise identical.
// STRUCTURE
//  - Package buzz_pkg: src encoding (SRC_NONE/ALARM/TIMER/CHIME), state encoding (IDLE, BEEP, GAP), BEEP_CNT_W = 8.
//  - One sub-module buzz_prio_enc: pending + eligibility mask -> highest src, plus "higher than cur" flag.
//  - Cadence counters and FSM stay in this module.
// TESTING (sim params BEEP_TICKS=2, GAP_TICKS=2, TIMEOUT_BEEPS=3, CHIME_BEEPS=2, SNOOZE_TICKS=10, tick every cycle)
//  1. chime_hit at cycle 0 -> tone_sel=3; tone_en high 2 ticks, low 2, high 2, low 2; then IDLE, busy=0, no dismissed.
//  2. timer_hit, no stop -> exactly 3 beeps at tone_sel=2, then IDLE; pending cleared.
//  3. chime active, alarm_hit during 1st BEEP -> chime completes beep 1 + gap, alarm takes over;
//     after alarm times out (3 beeps) chime replays 2 beeps from 0.
//  4. alarm active, stop_btn same cycle as tick at BEEP end -> IDLE next edge, dismissed=1 for 1 cycle, no GAP entered;
//     alarm_hit same cycle dropped.
//  5. rst asserted mid-BEEP with timer+chime pending -> tone_en=0 immediately; after release, IDLE with nothing pending.
//  6. (BUZZ_SNOOZE_EN) alarm beeping, snooze_btn -> tone off 10 ticks, alarm restarts beep 0;
//     a timer_hit during snooze is served at once.

Source files
------------

// File: rtl/buzz_pkg.sv
// Shared encodings for the buzzer scheduler: alarm sources, cadence states
// and the beep counter width.
package buzz_pkg;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_ALARM = 2'd1,
    SRC_TIMER = 2'd2,
    SRC_CHIME = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEEP = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int BEEP_CNT_W = 8;

  // One-hot pending-vector bit for a source (bit 0 is never used).
  function automatic logic [3:0] src_mask(input src_e s);
    src_mask = 4'b0001 << s;
  endfunction

endpackage

// File: rtl/buzz_if.sv
// Event/speaker bundle between the comparators, the scheduler and the tone generator.
interface buzz_if;
  logic       tick;
  logic       alarm_hit;
  logic       timer_hit;
  logic       chime_hit;
  logic       stop_btn;
  logic       snooze_btn;
  logic       tone_en;
  logic [1:0] tone_sel;
  logic       busy;
  logic       dismissed;

  modport master (
    output tick, alarm_hit, timer_hit, chime_hit, stop_btn, snooze_btn,
    input  tone_en, tone_sel, busy, dismissed
  );

  modport slave (
    input  tick, alarm_hit, timer_hit, chime_hit, stop_btn, snooze_btn,
    output tone_en, tone_sel, busy, dismissed
  );
endinterface

// File: rtl/buzz_prio_enc.sv
// Fixed-priority pick (alarm > timer > chime) among eligible pending sources,
// plus a flag telling whether that pick outranks the source currently served.
module buzz_prio_enc
  import buzz_pkg::*;
(
  input  logic [3:1] pending,
  input  logic [3:1] elig,
  input  src_e       cur,
  output src_e       best,
  output logic       higher
);

  logic [3:1] req_s;
  assign req_s = pending & elig;

  // Lower encoding means higher priority.
  always_comb begin
    best   = SRC_NONE;
    higher = 1'b0;
    if (req_s[1]) begin
      best = SRC_ALARM;
    end else if (req_s[2]) begin
      best = SRC_TIMER;
    end else if (req_s[3]) begin
      best = SRC_CHIME;
    end else begin
      best = SRC_NONE;
    end
    if (best != SRC_NONE && (cur == SRC_NONE || best < cur)) begin
      higher = 1'b1;
    end else begin
      higher = 1'b0;
    end
  end

endmodule

// File: rtl/buzzer_scheduler.sv
// Shares one piezo among alarm, timer and chime with a beep/gap cadence.
// Optional snooze for the alarm source is enabled with `define BUZZ_SNOOZE_EN.
module buzzer_scheduler
  import buzz_pkg::*;
#(
  parameter int TICK_W        = 16,
  parameter int BEEP_TICKS    = 50,
  parameter int GAP_TICKS     = 50,
  parameter int TIMEOUT_BEEPS = 60,
  parameter int CHIME_BEEPS   = 2,
  parameter int SNOOZE_TICKS  = 30000
) (
  input logic  clk,
  input logic  rst,
  buzz_if.slave bus
);

  if (BEEP_TICKS < 1 || BEEP_TICKS > (1 << TICK_W)) begin : g_bad_beep
    $error("BEEP_TICKS does not fit TICK_W");
  end
  if (GAP_TICKS < 1 || GAP_TICKS > (1 << TICK_W)) begin : g_bad_gap
    $error("GAP_TICKS does not fit TICK_W");
  end
  if (TIMEOUT_BEEPS < 1 || TIMEOUT_BEEPS > 255) begin : g_bad_timeout
    $error("TIMEOUT_BEEPS must be 1..255");
  end
  if (CHIME_BEEPS < 1 || CHIME_BEEPS > 255) begin : g_bad_chime
    $error("CHIME_BEEPS must be 1..255");
  end
  if (SNOOZE_TICKS < 1) begin : g_bad_snooze
    $error("SNOOZE_TICKS must be positive");
  end

  state_e                state_r;
  src_e                  cur_r;
  logic [3:0]            pending_r;
  logic [TICK_W-1:0]     tick_cnt_r;
  logic [BEEP_CNT_W-1:0] beep_cnt_r;
  logic                  dismissed_r;

  logic [3:0] hit_s;
  logic [3:0] pend_set_s;
  logic [3:1] elig_s;
  src_e       best_s;
  logic       higher_s;
  logic       done_s;
  logic       snooze_active_s;
  logic       snooze_req_s;

  assign hit_s      = {bus.chime_hit, bus.timer_hit, bus.alarm_hit, 1'b0};
  assign pend_set_s = pending_r | hit_s;
  assign elig_s     = {2'b11, ~snooze_active_s};

`ifdef BUZZ_SNOOZE_EN
  localparam int SNZ_W = $clog2(SNOOZE_TICKS + 1);
  logic [SNZ_W-1:0] snooze_cnt_r;

  assign snooze_active_s = (snooze_cnt_r != {SNZ_W{1'b0}});
  assign snooze_req_s    = bus.snooze_btn && (cur_r == SRC_ALARM) && (state_r != IDLE);

  // Snooze countdown: loaded by a snooze press, cleared by a dismiss while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snooze_cnt_r <= {SNZ_W{1'b0}};
    end else if (state_r != IDLE && !bus.stop_btn && snooze_req_s) begin
      snooze_cnt_r <= SNZ_W'(SNOOZE_TICKS);
    end else if (state_r == IDLE && bus.stop_btn && snooze_active_s) begin
      snooze_cnt_r <= {SNZ_W{1'b0}};
    end else if (bus.tick && snooze_active_s) begin
      snooze_cnt_r <= snooze_cnt_r - SNZ_W'(1);
    end else begin
      snooze_cnt_r <= snooze_cnt_r;
    end
  end
`else
  logic unused_snooze_btn_s;
  assign unused_snooze_btn_s = bus.snooze_btn;
  assign snooze_active_s     = 1'b0;
  assign snooze_req_s        = 1'b0;
`endif

  buzz_prio_enc u_prio (
    .pending (pending_r[3:1]),
    .elig    (elig_s),
    .cur     (cur_r),
    .best    (best_s),
    .higher  (higher_s)
  );

  // Session end: chime stops after its short burst, alarm/timer after the timeout count.
  always_comb begin
    done_s = 1'b0;
    if (cur_r == SRC_CHIME) begin
      done_s = (beep_cnt_r == BEEP_CNT_W'(CHIME_BEEPS));
    end else begin
      done_s = (beep_cnt_r == BEEP_CNT_W'(TIMEOUT_BEEPS));
    end
  end

  // Cadence FSM with event latching; stop_btn outranks tick and same-cycle hits of cur.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cur_r       <= SRC_NONE;
      pending_r   <= 4'b0000;
      tick_cnt_r  <= {TICK_W{1'b0}};
      beep_cnt_r  <= {BEEP_CNT_W{1'b0}};
      dismissed_r <= 1'b0;
    end else begin
      dismissed_r <= 1'b0;
      pending_r   <= pend_set_s;
      if (state_r == IDLE) begin
        if (bus.stop_btn && snooze_active_s) begin
          pending_r   <= pend_set_s & ~src_mask(SRC_ALARM);
          dismissed_r <= 1'b1;
        end else if (best_s != SRC_NONE) begin
          state_r    <= BEEP;
          cur_r      <= best_s;
          tick_cnt_r <= {TICK_W{1'b0}};
          beep_cnt_r <= {BEEP_CNT_W{1'b0}};
        end else begin
          cur_r <= SRC_NONE;
        end
      end else if (bus.stop_btn) begin
        pending_r   <= pend_set_s & ~src_mask(cur_r);
        state_r     <= IDLE;
        cur_r       <= SRC_NONE;
        dismissed_r <= 1'b1;
      end else if (snooze_req_s) begin
        state_r    <= IDLE;
        cur_r      <= SRC_NONE;
        tick_cnt_r <= {TICK_W{1'b0}};
        beep_cnt_r <= {BEEP_CNT_W{1'b0}};
      end else if (bus.tick) begin
        case (state_r)
          BEEP: begin
            if (tick_cnt_r == TICK_W'(BEEP_TICKS - 1)) begin
              state_r    <= GAP;
              tick_cnt_r <= {TICK_W{1'b0}};
              if (beep_cnt_r != {BEEP_CNT_W{1'b1}}) begin
                beep_cnt_r <= beep_cnt_r + BEEP_CNT_W'(1);
              end else begin
                beep_cnt_r <= beep_cnt_r;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TICK_W'(1);
            end
          end
          GAP: begin
            if (tick_cnt_r == TICK_W'(GAP_TICKS - 1)) begin
              tick_cnt_r <= {TICK_W{1'b0}};
              if (done_s) begin
                pending_r <= pend_set_s & ~src_mask(cur_r);
                state_r   <= IDLE;
                cur_r     <= SRC_NONE;
              end else if (higher_s) begin
                state_r    <= BEEP;
                cur_r      <= best_s;
                beep_cnt_r <= {BEEP_CNT_W{1'b0}};
              end else begin
                state_r <= BEEP;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + TICK_W'(1);
            end
          end
          default: begin
            state_r <= IDLE;
            cur_r   <= SRC_NONE;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.tone_en   = (state_r == BEEP);
  assign bus.tone_sel  = cur_r;
  assign bus.busy      = (state_r == BEEP) || (state_r == GAP);
  assign bus.dismissed = dismissed_r;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Scoreboard bench for buzzer_scheduler: each scenario queues the expected
// per-cycle speaker outputs, then replays its stimulus and pops/compares.
module tb_buzzer_scheduler;

  localparam int BT = 2;
  localparam int GT = 2;

  typedef struct {
    logic       en;
    logic [1:0] sel;
    logic       busy;
    logic       dis;
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t e;

  buzz_if bus();

  buzzer_scheduler #(
    .TICK_W(16), .BEEP_TICKS(BT), .GAP_TICKS(GT),
    .TIMEOUT_BEEPS(3), .CHIME_BEEPS(2), .SNOOZE_TICKS(10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input int n, input logic en, input logic [1:0] sel,
                      input logic busy, input logic dis);
    exp_t x;
    x.en = en; x.sel = sel; x.busy = busy; x.dis = dis;
    for (int i = 0; i < n; i++) exp_q.push_back(x);
  endtask

  task automatic push_beeps(input int beeps, input logic [1:0] sel);
    for (int i = 0; i < beeps; i++) begin
      push(BT, 1'b1, sel, 1'b1, 1'b0);
      push(GT, 1'b0, sel, 1'b1, 1'b0);
    end
  endtask

  function automatic string obs_str();
    return $sformatf("en=%b sel=%0d busy=%b dis=%b",
                     bus.tone_en, bus.tone_sel, bus.busy, bus.dismissed);
  endfunction

  function automatic string exp_str(input exp_t x);
    return $sformatf("en=%b sel=%0d busy=%b dis=%b", x.en, x.sel, x.busy, x.dis);
  endfunction

  task automatic clear_inputs();
    bus.alarm_hit = 1'b0; bus.timer_hit = 1'b0; bus.chime_hit = 1'b0;
    bus.stop_btn  = 1'b0; bus.snooze_btn = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.tick = 1'b1;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.tone_en, bus.tone_sel, bus.busy, bus.dismissed} !== 5'b0) begin
      failures++;
      $display("FAIL reset_state got %s required all zero", obs_str());
    end
    rst = 1'b0;
  endtask

  task automatic test_chime();
    push(1, 1'b0, 2'd0, 1'b0, 1'b0);
    push_beeps(2, 2'd3);
    push(3, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int c = 0; exp_q.size() != 0; c++) begin
      bus.chime_hit = (c == 0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.tone_en, bus.tone_sel, bus.busy, bus.dismissed} !== {e.en, e.sel, e.busy, e.dis}) begin
        failures++;
        $display("FAIL chime_cadence cycle %0d got %s required %s", c, obs_str(), exp_str(e));
      end
    end
    clear_inputs();
  endtask

  task automatic test_timer_timeout();
    push(1, 1'b0, 2'd0, 1'b0, 1'b0);
    push_beeps(3, 2'd2);
    push(4, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int c = 0; exp_q.size() != 0; c++) begin
      bus.timer_hit = (c == 0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.tone_en, bus.tone_sel, bus.busy, bus.dismissed} !== {e.en, e.sel, e.busy, e.dis}) begin
        failures++;
        $display("FAIL timer_timeout cycle %0d got %s required %s", c, obs_str(), exp_str(e));
      end
    end
    clear_inputs();
  endtask

  task automatic test_preempt();
    push(1, 1'b0, 2'd0, 1'b0, 1'b0);
    push_beeps(1, 2'd3);
    push_beeps(3, 2'd1);
    push(1, 1'b0, 2'd0, 1'b0, 1'b0);
    push_beeps(2, 2'd3);
    push(3, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int c = 0; exp_q.size() != 0; c++) begin
      bus.chime_hit = (c == 0);
      bus.alarm_hit = (c == 2);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.tone_en, bus.tone_sel, bus.busy, bus.dismissed} !== {e.en, e.sel, e.busy, e.dis}) begin
        failures++;
        $display("FAIL preempt cycle %0d got %s required %s", c, obs_str(), exp_str(e));
      end
    end
    clear_inputs();
  endtask

  task automatic test_stop();
    push(1, 1'b0, 2'd0, 1'b0, 1'b0);
    push(BT, 1'b1, 2'd1, 1'b1, 1'b0);
    push(1, 1'b0, 2'd0, 1'b0, 1'b1);
    push(5, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int c = 0; exp_q.size() != 0; c++) begin
      bus.alarm_hit = (c == 0) || (c == 3);
      bus.stop_btn  = (c == 3) || (c == 5);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.tone_en, bus.tone_sel, bus.busy, bus.dismissed} !== {e.en, e.sel, e.busy, e.dis}) begin
        failures++;
        $display("FAIL stop_dismiss cycle %0d got %s required %s", c, obs_str(), exp_str(e));
      end
    end
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    push(1, 1'b0, 2'd0, 1'b0, 1'b0);
    push_beeps(3, 2'd2);
    push(1, 1'b0, 2'd0, 1'b0, 1'b0);
    push_beeps(2, 2'd3);
    push(3, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int c = 0; exp_q.size() != 0; c++) begin
      bus.timer_hit = (c == 0);
      bus.chime_hit = (c == 0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.tone_en, bus.tone_sel, bus.busy, bus.dismissed} !== {e.en, e.sel, e.busy, e.dis}) begin
        failures++;
        $display("FAIL back_to_back cycle %0d got %s required %s", c, obs_str(), exp_str(e));
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_beep();
    push(1, 1'b0, 2'd0, 1'b0, 1'b0);
    push(BT, 1'b1, 2'd2, 1'b1, 1'b0);
    for (int c = 0; exp_q.size() != 0; c++) begin
      bus.timer_hit = (c == 0);
      bus.chime_hit = (c == 0);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.tone_en, bus.tone_sel, bus.busy, bus.dismissed} !== {e.en, e.sel, e.busy, e.dis}) begin
        failures++;
        $display("FAIL reset_mid_beep_pre cycle %0d got %s required %s", c, obs_str(), exp_str(e));
      end
    end
    clear_inputs();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.tone_en, bus.tone_sel, bus.busy} !== 4'b0) begin
      failures++;
      $display("FAIL async_reset got %s required en=0 sel=0 busy=0", obs_str());
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    push(6, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int c = 0; exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.tone_en, bus.tone_sel, bus.busy, bus.dismissed} !== {e.en, e.sel, e.busy, e.dis}) begin
        failures++;
        $display("FAIL reset_mid_beep_post cycle %0d got %s required %s", c, obs_str(), exp_str(e));
      end
    end
  endtask

`ifdef BUZZ_SNOOZE_EN
  task automatic test_snooze();
    // Snooze, wait it out, alarm restarts from beep 0, then dismiss it.
    push(1, 1'b0, 2'd0, 1'b0, 1'b0);
    push(BT, 1'b1, 2'd1, 1'b1, 1'b0);
    push(11, 1'b0, 2'd0, 1'b0, 1'b0);
    push(1, 1'b1, 2'd1, 1'b1, 1'b0);
    push(1, 1'b0, 2'd0, 1'b0, 1'b1);
    push(2, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int c = 0; exp_q.size() != 0; c++) begin
      bus.alarm_hit  = (c == 0);
      bus.snooze_btn = (c == 3);
      bus.stop_btn   = (c == 15);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.tone_en, bus.tone_sel, bus.busy, bus.dismissed} !== {e.en, e.sel, e.busy, e.dis}) begin
        failures++;
        $display("FAIL snooze_restart cycle %0d got %s required %s", c, obs_str(), exp_str(e));
      end
    end
    // Timer served during snooze; idle dismiss then cancels the snoozed alarm.
    push(1, 1'b0, 2'd0, 1'b0, 1'b0);
    push(1, 1'b1, 2'd1, 1'b1, 1'b0);
    push(1, 1'b0, 2'd0, 1'b0, 1'b0);
    push(1, 1'b1, 2'd2, 1'b1, 1'b0);
    push(2, 1'b0, 2'd0, 1'b0, 1'b1);
    push(15, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int c = 0; exp_q.size() != 0; c++) begin
      bus.alarm_hit  = (c == 0);
      bus.snooze_btn = (c == 2);
      bus.timer_hit  = (c == 2);
      bus.stop_btn   = (c == 4) || (c == 5);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({bus.tone_en, bus.tone_sel, bus.busy, bus.dismissed} !== {e.en, e.sel, e.busy, e.dis}) begin
        failures++;
        $display("FAIL snooze_timer cycle %0d got %s required %s", c, obs_str(), exp_str(e));
      end
    end
    clear_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_chime();
    test_timer_timeout();
    test_preempt();
    test_stop();
    test_back_to_back();
    test_reset_mid_beep();
`ifdef BUZZ_SNOOZE_EN
    test_snooze();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
